// File: rtl/regfile_operand_stage.sv
// regfile_operand_stage
//
// 32-entry, two-read / one-write register file feeding an ID/EX-style
// operand register that drives the ALU A/B buses directly.
//
// Optional feature (macro RF_WRITE_BYPASS_EN):
//   defined   -> write-first: a write-back to the register being decoded in
//                the same cycle is forwarded into the read value.
//   undefined -> read-before-write: reads see the pre-edge contents; the
//                pipeline must stall once for a same-cycle dependency.
//   The stall refresh of a held operand pair is active in both builds.
//
// Handshake: out_valid qualifies A/B. There is no ready; the consumer holds
// the pair in place by asserting stall, and flush discards it. A/B always
// load on a non-stalled, non-flushed edge, even when in_valid=0.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset (clears storage and outputs)
//   in_valid  decode slot holds a valid instruction
//   rs_addr   source register for A
//   rt_addr   source register for B
//   stall     hold the output register (with write-back refresh)
//   flush     clear the output register (wins over stall)
//   we        write-back enable
//   wr_addr   write-back register (writes to register 0 are dropped)
//   wr_data   write-back data
//   A, B      registered operands to the ALU
//   out_valid A/B hold a valid operand pair
module regfile_operand_stage #(
  parameter int width      = 32,
  parameter int addr_width = 5,
  parameter int depth      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [addr_width-1:0] rs_addr,
  input  logic [addr_width-1:0] rt_addr,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  we,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [width-1:0]      wr_data,
  output logic [width-1:0]      A,
  output logic [width-1:0]      B,
  output logic                  out_valid
);

  logic [width-1:0]      mem_q [depth];
  logic [width-1:0]      mem_d [depth];
  logic [width-1:0]      a_q, a_d;
  logic [width-1:0]      b_q, b_d;
  logic                  valid_q, valid_d;
  logic [addr_width-1:0] rs_cap_q, rs_cap_d;
  logic [addr_width-1:0] rt_cap_q, rt_cap_d;

  logic                  wr_hit;
  logic [width-1:0]      rd_a;
  logic [width-1:0]      rd_b;

  // Register 0 is hard-wired to zero, so a write to it is neither stored
  // nor forwarded anywhere.
  assign wr_hit = we && (wr_addr != '0);

  // Storage next state
  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read values rv(rs_addr) / rv(rt_addr)
  always_comb begin
    rd_a = (rs_addr == '0) ? '0 : mem_q[rs_addr];
    rd_b = (rt_addr == '0) ? '0 : mem_q[rt_addr];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_hit && (wr_addr == rs_addr)) begin
      rd_a = wr_data;
    end
    if (wr_hit && (wr_addr == rt_addr)) begin
      rd_b = wr_data;
    end
`endif
  end

  // Output register: flush > stall > load (reset handled in the flop)
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    valid_d  = valid_q;
    rs_cap_d = rs_cap_q;
    rt_cap_d = rt_cap_q;
    if (flush) begin
      a_d      = '0;
      b_d      = '0;
      valid_d  = 1'b0;
      rs_cap_d = '0;
      rt_cap_d = '0;
    end else if (stall) begin
      // A held pair must not go stale while a write-back retires into one
      // of its source registers. Captured address 0 never matches wr_hit.
      if (wr_hit && (wr_addr == rs_cap_q)) begin
        a_d = wr_data;
      end
      if (wr_hit && (wr_addr == rt_cap_q)) begin
        b_d = wr_data;
      end
    end else begin
      a_d      = rd_a;
      b_d      = rd_b;
      valid_d  = in_valid;
      rs_cap_d = rs_addr;
      rt_cap_d = rt_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      a_q      <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      rs_cap_q <= '0;
      rt_cap_q <= '0;
    end else begin
      mem_q    <= mem_d;
      a_q      <= a_d;
      b_q      <= b_d;
      valid_q  <= valid_d;
      rs_cap_q <= rs_cap_d;
      rt_cap_q <= rt_cap_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_regfile_operand_stage.sv
module tb_regfile_operand_stage;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int EW = 1 + 2 * W;

  // clock / reset block
  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [AW-1:0] rs_addr, rt_addr;
  logic          stall, flush, we;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  A, B;
  logic          out_valid;

  always #5 clk = ~clk;

  regfile_operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .stall     (stall),
    .flush     (flush),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .A         (A),
    .B         (B),
    .out_valid (out_valid)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            id_q[$];
  int            n_vec = 0;
  int            n_miss = 0;
  int            vec_id = 0;

`ifdef RF_WRITE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  // driver: inputs applied on the falling edge, expected outputs after the
  // following rising edge pushed into the scoreboard
  task automatic vec(input logic rst, input logic iv,
                     input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                     input logic st, input logic fl,
                     input logic w, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                     input logic ev, input logic [W-1:0] ea, input logic [W-1:0] eb);
    @(negedge clk);
    reset    = rst;
    in_valid = iv;
    rs_addr  = rs;
    rt_addr  = rt;
    stall    = st;
    flush    = fl;
    we       = w;
    wr_addr  = wa;
    wr_data  = wd;
    exp_q.push_back({ev, ea, eb});
    id_q.push_back(vec_id);
    vec_id++;
    @(posedge clk);
  endtask

  // monitor: compares one popped expectation per rising edge
  initial begin
    logic [EW-1:0] e;
    int            id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        n_vec++;
        if ({out_valid, A, B} !== e) begin
          n_miss++;
          $display("FAIL vec%0d: got v=%0b A=%h B=%h, expected v=%0b A=%h B=%h",
                   id, out_valid, A, B, e[EW-1], e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  logic [W-1:0] ea9, eb9;

  initial begin
    reset = 1'b1; in_valid = 1'b0; rs_addr = '0; rt_addr = '0;
    stall = 1'b0; flush = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;

    //   rst iv rs  rt  st fl we wa  wd            ev ea            eb
    // reset state and reset priority
    vec(1, 0, 0,  0,  0, 0, 0, 0,  32'h0,         0, 32'h0,        32'h0);
    vec(0, 1, 5,  6,  0, 0, 0, 0,  32'h0,         1, 32'h0,        32'h0);
    vec(1, 1, 5,  6,  1, 0, 1, 5,  32'hDEADBEEF,  0, 32'h0,        32'h0);
    vec(0, 1, 5,  5,  0, 0, 0, 0,  32'h0,         1, 32'h0,        32'h0);
    // write then read; register 0
    vec(0, 0, 0,  0,  0, 0, 1, 3,  32'h12345678,  0, 32'h0,        32'h0);
    vec(0, 1, 3,  0,  0, 0, 0, 0,  32'h0,         1, 32'h12345678, 32'h0);
    vec(0, 1, 0,  0,  0, 0, 1, 0,  32'hFFFFFFFF,  1, 32'h0,        32'h0);
    vec(0, 1, 0,  3,  0, 0, 0, 0,  32'h0,         1, 32'h0,        32'h12345678);
    // same-cycle write/read of r7
    ea9 = BYPASS ? 32'hA5A5A5A5 : 32'h0;
    eb9 = ea9;
    vec(0, 1, 7,  7,  0, 0, 1, 7,  32'hA5A5A5A5,  1, ea9,          eb9);
    vec(0, 1, 7,  0,  0, 0, 0, 0,  32'h0,         1, 32'hA5A5A5A5, 32'h0);
    // stall with refresh
    vec(0, 0, 0,  0,  0, 0, 1, 4,  32'h1,         0, 32'h0,        32'h0);
    vec(0, 0, 0,  0,  0, 0, 1, 9,  32'h55,        0, 32'h0,        32'h0);
    vec(0, 1, 4,  9,  0, 0, 0, 0,  32'h0,         1, 32'h1,        32'h55);
    vec(0, 0, 0,  0,  1, 0, 0, 0,  32'h0,         1, 32'h1,        32'h55);
    vec(0, 0, 0,  0,  1, 0, 1, 4,  32'h2,         1, 32'h2,        32'h55);
    vec(0, 0, 0,  0,  1, 0, 0, 0,  32'h0,         1, 32'h2,        32'h55);
    vec(0, 1, 9,  4,  0, 0, 0, 0,  32'h0,         1, 32'h55,       32'h2);
    vec(0, 0, 0,  0,  1, 0, 1, 4,  32'h3,         1, 32'h55,       32'h3);
    // flush beats stall, no refresh, captured addresses cleared
    vec(0, 1, 1,  1,  1, 1, 1, 9,  32'h99,        0, 32'h0,        32'h0);
    vec(0, 1, 1,  1,  1, 0, 1, 9,  32'h77,        0, 32'h0,        32'h0);
    vec(0, 1, 9,  4,  0, 0, 0, 0,  32'h0,         1, 32'h77,       32'h3);
    // in_valid low still loads operands; one-cycle valid pulse
    vec(0, 0, 3,  0,  0, 0, 0, 0,  32'h0,         0, 32'h12345678, 32'h0);
    vec(0, 1, 3,  3,  0, 0, 0, 0,  32'h0,         1, 32'h12345678, 32'h12345678);
    vec(0, 0, 3,  9,  0, 0, 0, 0,  32'h0,         0, 32'h12345678, 32'h77);
    // reset clears storage
    vec(1, 1, 3,  9,  0, 0, 0, 0,  32'h0,         0, 32'h0,        32'h0);
    vec(0, 1, 3,  9,  0, 0, 0, 0,  32'h0,         1, 32'h0,        32'h0);
    vec(0, 0, 0,  0,  0, 0, 0, 0,  32'h0,         0, 32'h0,        32'h0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
